// File: rtl/qr_result_serializer.sv
// ---------------------------------------------------------------------------
// qr_result_serializer
//
// Captures completed QR engine results (R: 320 bits, y-hat: 160 bits) on the
// engine's read-valid pulse into a DEPTH-entry FIFO. It then streams each
// result as 15 words of 32 bits over a valid/ready handshake: R words 0..9
// come first, then y-hat words 0..4. The first and last word of every frame
// of FRAME_LEN results are tagged. Dropped results (FIFO full) and
// end-of-frame pulses that arrive off a frame boundary raise sticky flags.
//
// Parameters
//   DEPTH       result entries buffered (power of two, >= 2)
//   FRAME_LEN   results per frame
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_rd_vld     one-cycle result strobe from the engine
//   i_last_data  engine end-of-frame pulse (monitored only)
//   i_y_hat      y-hat vector, 160 bits
//   i_r          R upper-triangle entries, 320 bits
//   i_ready      downstream accepts the current word
//   o_valid      o_data holds a valid word
//   o_data       output word, 32 bits (0 when idle)
//   o_sof        word 0 of result 0 of a frame
//   o_eof        word 14 of result FRAME_LEN-1 of a frame
//   o_overflow   sticky: a result was dropped because the FIFO was full
//   o_frame_err  sticky: end-of-frame seen off a frame boundary
// ---------------------------------------------------------------------------
module qr_result_serializer #(
   parameter int DEPTH     = 2,
   parameter int FRAME_LEN = 10
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_rd_vld,
   input  logic         i_last_data,
   input  logic [159:0] i_y_hat,
   input  logic [319:0] i_r,
   input  logic         i_ready,
   output logic         o_valid,
   output logic [31:0]  o_data,
   output logic         o_sof,
   output logic         o_eof,
   output logic         o_overflow,
   output logic         o_frame_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [FW-1:0] FRM_LAST = FW'(FRAME_LEN - 1);
   localparam logic [3:0]    WLAST    = 4'd14;

   // Entry layout {y_hat, r}: word k of the result sits at bits [32k+31:32k],
   // so R words 0..9 and y-hat words 0..4 fall out of one indexed select.
   logic [479:0]  mem [DEPTH];
   logic [479:0]  head;
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [CW-1:0] count;
   logic [3:0]    widx;
   logic [FW-1:0] ridx;
   logic [FW-1:0] pcnt;
   logic          overflow;
   logic          frame_err;
   logic          xfer;
   logic          pop;
   logic          push_ok;

   function automatic logic [31:0] word_sel(input logic [479:0] e,
                                             input logic [3:0]   k);
      return e[{k, 5'b0} +: 32];
   endfunction

   assign head    = mem[rptr];
   assign xfer    = (count != '0) && i_ready;
   assign pop     = xfer && (widx == WLAST);
   // A full FIFO still takes a new result when the head leaves this cycle.
   assign push_ok = i_rd_vld && ((count < CNT_FULL) || pop);

   assign o_valid     = (count != '0);
   assign o_data      = o_valid ? word_sel(head, widx) : '0;
   assign o_sof       = o_valid && (ridx == '0) && (widx == '0);
   assign o_eof       = o_valid && (ridx == FRM_LAST) && (widx == WLAST);
   assign o_overflow  = overflow;
   assign o_frame_err = frame_err;

   // Result storage: data only, not reset.
   always_ff @(posedge i_clk) begin
      if (push_ok) begin
         mem[wptr] <= {i_y_hat, i_r};
      end
   end

   // Pointers, counters and sticky flags.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         widx      <= '0;
         ridx      <= '0;
         pcnt      <= '0;
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (push_ok) begin
            wptr <= wptr + 1'b1;
            pcnt <= (pcnt == FRM_LAST) ? '0 : pcnt + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
            ridx <= (ridx == FRM_LAST) ? '0 : ridx + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (xfer) begin
            widx <= pop ? 4'd0 : widx + 4'd1;
         end
         if (i_rd_vld && !push_ok) begin
            overflow <= 1'b1;
         end
         // pcnt is zero only on a frame boundary of accepted results.
         if (i_last_data && (pcnt != '0)) begin
            frame_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_qr_result_serializer.sv
module tb_qr_result_serializer;

   localparam int DEPTH     = 2;
   localparam int FRAME_LEN = 10;

   logic         i_clk = 1'b0;
   logic         i_rst = 1'b1;
   logic         i_rd_vld = 1'b0;
   logic         i_last_data = 1'b0;
   logic [159:0] i_y_hat = '0;
   logic [319:0] i_r = '0;
   logic         i_ready = 1'b0;
   logic         o_valid;
   logic [31:0]  o_data;
   logic         o_sof;
   logic         o_eof;
   logic         o_overflow;
   logic         o_frame_err;

   qr_result_serializer #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_rd_vld    (i_rd_vld),
      .i_last_data (i_last_data),
      .i_y_hat     (i_y_hat),
      .i_r         (i_r),
      .i_ready     (i_ready),
      .o_valid     (o_valid),
      .o_data      (o_data),
      .o_sof       (o_sof),
      .o_eof       (o_eof),
      .o_overflow  (o_overflow),
      .o_frame_err (o_frame_err)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;

   // Reference model: queue of buffered results, words already sent from the
   // head, frame position of the head, accepted-push position, sticky flags.
   logic [479:0] mq[$];
   int           msent;
   int           mridx;
   int           mpcnt;
   int           acc_cnt;
   bit           movf;
   bit           mferr;

   // Observed stream (DUT side) for directed checks.
   logic [31:0]  wlog[$];
   int           eof_cnt;
   int           sof_cnt;
   bit           hold_prev;
   logic [31:0]  prev_data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [479:0] rand_entry();
      logic [479:0] e;
      for (int k = 0; k < 15; k++) e[k*32 +: 32] = $urandom;
      return e;
   endfunction

   function automatic logic [479:0] pat_entry();
      logic [479:0] e;
      for (int k = 0; k < 10; k++) e[k*32 +: 32] = 32'h1000_0000 + 32'(k);
      for (int k = 10; k < 15; k++) e[k*32 +: 32] = 32'h2000_0000 + 32'(k - 10);
      return e;
   endfunction

   function automatic logic [31:0] word_of(input logic [479:0] e, input int k);
      return e[k*32 +: 32];
   endfunction

   task automatic clr_stats();
      wlog.delete();
      eof_cnt = 0;
      sof_cnt = 0;
      acc_cnt = 0;
   endtask

   // One clock cycle, entered and left at the falling edge.
   task automatic step(input bit rv, input logic [479:0] e, input bit ld, input bit rdy);
      bit          ev, es, ee, popping, accept;
      logic [31:0] ed;
      i_rd_vld    = rv;
      {i_y_hat, i_r} = e;
      i_last_data = ld;
      i_ready     = rdy;
      #1;
      ev = (mq.size() != 0);
      ed = '0;
      es = 1'b0;
      ee = 1'b0;
      if (ev) begin
         ed = word_of(mq[0], msent);
         es = (mridx == 0) && (msent == 0);
         ee = (mridx == FRAME_LEN - 1) && (msent == 14);
      end
      check("valid", 32'(o_valid), 32'(ev));
      check("data", o_data, ed);
      check("sof", 32'(o_sof), 32'(es));
      check("eof", 32'(o_eof), 32'(ee));
      check("overflow", 32'(o_overflow), 32'(movf));
      check("frame_err", 32'(o_frame_err), 32'(mferr));
      if (hold_prev) check("hold_data", o_data, prev_data);
      hold_prev = o_valid && !rdy;
      prev_data = o_data;
      if (o_valid && rdy) begin
         wlog.push_back(o_data);
         if (o_eof) eof_cnt++;
         if (o_sof) sof_cnt++;
      end
      @(posedge i_clk);
      popping = ev && rdy && (msent == 14);
      accept  = 1'b0;
      if (ld && mpcnt != 0) mferr = 1'b1;
      if (rv) begin
         if (mq.size() < DEPTH || popping) begin
            accept  = 1'b1;
            acc_cnt++;
            mpcnt   = (mpcnt + 1) % FRAME_LEN;
         end else begin
            movf = 1'b1;
         end
      end
      if (ev && rdy) begin
         msent++;
         if (msent == 15) begin
            mq.delete(0);
            msent = 0;
            mridx = (mridx + 1) % FRAME_LEN;
         end
      end
      if (accept) mq.push_back(e);
      @(negedge i_clk);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, rdy);
   endtask

   task automatic do_reset();
      i_rst       = 1'b1;
      i_rd_vld    = 1'b0;
      i_last_data = 1'b0;
      i_ready     = 1'b0;
      #1;
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_data", o_data, 32'd0);
      check("rst_sof", 32'(o_sof), 32'd0);
      check("rst_eof", 32'(o_eof), 32'd0);
      check("rst_ovf", 32'(o_overflow), 32'd0);
      check("rst_ferr", 32'(o_frame_err), 32'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      mq.delete();
      msent     = 0;
      mridx     = 0;
      mpcnt     = 0;
      movf      = 1'b0;
      mferr     = 1'b0;
      hold_prev = 1'b0;
      clr_stats();
   endtask

   initial begin
      logic [479:0] e1, e2, e3, ep;
      int rdy_r;

      @(negedge i_clk);
      do_reset();

      // Single patterned result, continuous ready.
      ep = pat_entry();
      step(1'b1, ep, 1'b0, 1'b1);
      for (int i = 0; i < 15; i++) begin
         check("t1_vld", 32'(o_valid), 32'd1);
         step(1'b0, '0, 1'b0, 1'b1);
      end
      check("t1_idle", 32'(o_valid), 32'd0);
      check("t1_words", 32'(wlog.size()), 32'd15);
      check("t1_sof_cnt", 32'(sof_cnt), 32'd1);
      if (wlog.size() == 15) begin
         for (int k = 0; k < 10; k++) check("t1_r", wlog[k], 32'h1000_0000 + 32'(k));
         for (int k = 10; k < 15; k++) check("t1_y", wlog[k], 32'h2000_0000 + 32'(k - 10));
      end

      // One full frame, results 20 cycles apart, end-of-frame 2 cycles after the 10th.
      do_reset();
      for (int r = 0; r < 10; r++) begin
         step(1'b1, rand_entry(), 1'b0, 1'b1);
         if (r == 9) begin
            idle(1, 1'b1);
            step(1'b0, '0, 1'b1, 1'b1);
            idle(17, 1'b1);
         end else begin
            idle(19, 1'b1);
         end
      end
      idle(5, 1'b1);
      check("t2_eof_cnt", 32'(eof_cnt), 32'd1);
      check("t2_sof_cnt", 32'(sof_cnt), 32'd1);
      check("t2_words", 32'(wlog.size()), 32'd150);
      check("t2_ferr", 32'(o_frame_err), 32'd0);
      check("t2_ovf", 32'(o_overflow), 32'd0);

      // Backpressure: three results while stalled, the third is dropped.
      do_reset();
      e1 = rand_entry();
      e2 = rand_entry();
      e3 = rand_entry();
      step(1'b1, e1, 1'b0, 1'b0);
      idle(12, 1'b0);
      step(1'b1, e2, 1'b0, 1'b0);
      idle(12, 1'b0);
      step(1'b1, e3, 1'b0, 1'b0);
      idle(13, 1'b0);
      check("t3_ovf", 32'(o_overflow), 32'd1);
      idle(60, 1'b1);
      check("t3_words", 32'(wlog.size()), 32'd30);
      if (wlog.size() == 30) begin
         for (int k = 0; k < 15; k++) check("t3_res1", wlog[k], word_of(e1, k));
         for (int k = 0; k < 15; k++) check("t3_res2", wlog[15 + k], word_of(e2, k));
      end

      // Random ready with random result spacing.
      do_reset();
      for (int r = 0; r < 20; r++) begin
         rdy_r = $urandom_range(0, 1);
         step(1'b1, rand_entry(), 1'b0, rdy_r[0]);
         for (int i = 0; i < int'($urandom_range(19, 39)); i++) begin
            rdy_r = $urandom_range(0, 1);
            step(1'b0, '0, 1'b0, rdy_r[0]);
         end
      end
      idle(60, 1'b1);
      check("t4_words", 32'(wlog.size()), 32'(15 * acc_cnt));

      // End-of-frame pulse after four results.
      do_reset();
      for (int r = 0; r < 4; r++) begin
         step(1'b1, rand_entry(), 1'b0, 1'b1);
         idle(19, 1'b1);
      end
      step(1'b0, '0, 1'b1, 1'b1);
      check("t5_ferr", 32'(o_frame_err), 32'd1);
      for (int r = 0; r < 2; r++) begin
         step(1'b1, rand_entry(), 1'b0, 1'b1);
         idle(19, 1'b1);
      end
      check("t5_ferr_hold", 32'(o_frame_err), 32'd1);
      check("t5_words", 32'(wlog.size()), 32'd90);

      // Reset in the middle of a result, then a fresh frame.
      do_reset();
      step(1'b1, rand_entry(), 1'b0, 1'b1);
      idle(7, 1'b1);
      do_reset();
      ep = rand_entry();
      step(1'b1, ep, 1'b0, 1'b1);
      check("t6_sof", 32'(o_sof), 32'd1);
      check("t6_w0", o_data, word_of(ep, 0));
      idle(20, 1'b1);
      check("t6_words", 32'(wlog.size()), 32'd15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
